// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master arbiter: FSM state codes,
// default bus widths and the timeout counter width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

  // Wide enough to hold the value TIMEOUT_CYCLES itself.
  function automatic int timeout_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from last_grant+1 upward, wrapping
// modulo N, and returns the first pending request as one-hot and binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // k = N revisits last_grant itself, so a lone requester is re-granted.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among N requesters.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_rr_master_arbiter
  import apb_pkg::*;
#(
  parameter int N              = 4,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state_reg, state_next;
  logic            psel_reg, psel_next;
  logic            penable_reg, penable_next;
  logic            pwrite_reg, pwrite_next;
  logic [AW-1:0]   paddr_reg, paddr_next;
  logic [DW-1:0]   pwdata_reg, pwdata_next;
  logic [N-1:0]    req_ready_reg, req_ready_next;
  logic [N-1:0]    rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [IW-1:0]   gidx_reg, gidx_next;
  logic [IW-1:0]   last_grant_reg, last_grant_next;
  logic            finish;
  logic            abort;

  logic [N-1:0]    arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [AW-1:0]   addr_arr  [N];
  logic [DW-1:0]   wdata_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end
  endgenerate

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .idx        (arb_idx),
    .any        (arb_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = timeout_width(TIMEOUT_CYCLES);
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          rsp_err_reg, rsp_err_next;
  assign rsp_err = rsp_err_reg;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    psel_next       = psel_reg;
    penable_next    = penable_reg;
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    req_ready_next  = '0;
    rsp_valid_next  = '0;
    rsp_rdata_next  = rsp_rdata_reg;
    gidx_next       = gidx_reg;
    last_grant_next = last_grant_reg;
    finish          = 1'b0;
    abort           = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    rsp_err_next    = rsp_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          paddr_next     = addr_arr[arb_idx];
          pwdata_next    = wdata_arr[arb_idx];
          pwrite_next    = req_write[arb_idx];
          psel_next      = 1'b1;
          req_ready_next = arb_grant;
          gidx_next      = arb_idx;
          state_next     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_next = 1'b1;
        state_next   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_next     = '0;
`endif
      end
      ST_ACCESS: begin
        finish = PREADY;
`ifdef APB_TIMEOUT_EN
        // A slave that answers on the abort cycle still completes normally.
        if (!PREADY) begin
          if (cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            finish = 1'b1;
            abort  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        rsp_err_next = finish ? abort : rsp_err_reg;
`endif
        if (finish) begin
          psel_next                = 1'b0;
          penable_next             = 1'b0;
          rsp_valid_next[gidx_reg] = 1'b1;
          rsp_rdata_next           = (pwrite_reg || abort) ? '0 : PRDATA;
          last_grant_next          = gidx_reg;
          state_next               = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg      <= ST_IDLE;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_rdata_reg  <= '0;
      gidx_reg       <= '0;
      last_grant_reg <= IW'(N - 1);
`ifdef APB_TIMEOUT_EN
      cnt_reg        <= '0;
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      gidx_reg       <= gidx_next;
      last_grant_reg <= last_grant_next;
`ifdef APB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      rsp_err_reg    <= rsp_err_next;
`endif
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign PSEL      = psel_reg;
  assign PENABLE   = penable_reg;
  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench for apb_rr_master_arbiter: transaction-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_apb_rr_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;

  apb_rr_master_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one active transfer (m_cur, -1 when bus free) and the
  // number of edges since it was captured (m_age).
  int            m_cur  = -1;
  int            m_age  = 0;
  int            m_wait = 0;
  int            m_last = N - 1;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_write = 1'b0;
  logic [N-1:0]  m_rdy   = '0;
  logic [N-1:0]  m_rsp   = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err   = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  initial forever begin
    @(posedge PCLK or posedge PRESET);
    if (PRESET) begin
      m_cur = -1; m_age = 0; m_wait = 0; m_last = N - 1;
      m_addr = '0; m_wdata = '0; m_write = 1'b0;
      m_rdy = '0; m_rsp = '0; m_rdata = '0; m_err = 1'b0;
    end else begin
      int  g;
      bit  fin;
      bit  ab;
      fin = 1'b0;
      ab  = 1'b0;
      m_rdy = '0;
      m_rsp = '0;
      if (m_cur < 0) begin
        g = rr_pick(req_valid, m_last);
        if (g >= 0) begin
          m_cur   = g;
          m_age   = 0;
          m_addr  = req_addr[g*AW +: AW];
          m_wdata = req_wdata[g*DW +: DW];
          m_write = req_write[g];
          m_rdy[g] = 1'b1;
        end
      end else if (m_age == 0) begin
        m_age  = 1;
        m_wait = 0;
      end else if (PREADY) begin
        fin = 1'b1;
      end else begin
        m_wait++;
`ifdef APB_TIMEOUT_EN
        if (m_wait == TO) begin
          fin = 1'b1;
          ab  = 1'b1;
        end
`endif
      end
      if (fin) begin
        m_rsp[m_cur] = 1'b1;
        m_rdata = (m_write || ab) ? '0 : PRDATA;
        m_err   = ab;
        m_last  = m_cur;
        m_cur   = -1;
      end
    end
  end

  // Compare process: outputs checked every falling edge outside reset.
  initial forever begin
    @(negedge PCLK);
    if (!PRESET) begin
      check("busy", busy, m_cur >= 0);
      check("psel", PSEL, m_cur >= 0);
      check("penable", PENABLE, (m_cur >= 0) && (m_age >= 1));
      check("paddr", PADDR, m_addr);
      check("pwdata", PWDATA, m_wdata);
      check("pwrite", PWRITE, m_write);
      check("req_ready", req_ready, m_rdy);
      check("rsp_valid", rsp_valid, m_rsp);
      if (m_rsp != 0) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready != 0) begin
        for (int b = 0; b < N; b++) if (req_ready[b]) g = b;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_grant: got no req_ready, expected one within 20 cycles");
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    tick();
    tick();
    PRESET = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int n;
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_rsp", rsp_valid, 4'b0000);
    check("rst_paddr", PADDR, 32'h0);
    PRESET = 1'b0;

    // Single read
    set_req(0, 1'b0, 32'h10, 32'h0);
    req_valid = 4'b0001; PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
    tick();
    check("t1_ready", req_ready, 4'b0001);
    check("t1_psel", PSEL, 1'b1);
    check("t1_pen0", PENABLE, 1'b0);
    check("t1_paddr", PADDR, 32'h10);
    req_valid = '0;
    tick();
    check("t1_pen1", PENABLE, 1'b1);
    check("t1_ready_off", req_ready, 4'b0000);
    tick();
    check("t1_rsp", rsp_valid, 4'b0001);
    check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    check("t1_err", rsp_err, 1'b0);
    check("t1_psel_off", PSEL, 1'b0);
    tick();
    check("t1_rsp_pulse", rsp_valid, 4'b0000);

    // Write with three wait states
    set_req(2, 1'b1, 32'h20, 32'h1234);
    req_valid = 4'b0100; PREADY = 1'b0;
    tick();
    check("t2_ready", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_sel", {PSEL, PENABLE}, 2'b11);
      check("t2_hold_addr", PADDR, 32'h20);
      check("t2_hold_wdata", PWDATA, 32'h1234);
      check("t2_no_rsp", rsp_valid, 4'b0000);
      PREADY = (i == 3);
      tick();
    end
    check("t2_rsp", rsp_valid, 4'b0100);
    check("t2_rdata", rsp_rdata, 32'h0);
    PREADY = 1'b0;
    tick();
    check("t2_rsp_once", rsp_valid, 4'b0000);

    // Round-robin with all requesters busy
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h100 + 32'(i), 32'hA0 + 32'(i));
    req_valid = 4'b1111; PREADY = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(g);
      check("t3_order", g, j % N);
    end
    req_valid = '0;
    repeat (3) tick();

    // Skip and wrap after last_grant = 2
    req_valid = 4'b0100;
    wait_grant(g);
    check("t4_pre", g, 2);
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b0011;
    wait_grant(g);
    check("t4_wrap0", g, 0);
    wait_grant(g);
    check("t4_then1", g, 1);
    req_valid = '0;
    repeat (4) tick();

    // Reset in the middle of ACCESS
    set_req(3, 1'b0, 32'h30, 32'h0);
    req_valid = 4'b1000; PREADY = 1'b0;
    tick();
    req_valid = '0;
    tick();
    check("t5_in_access", PENABLE, 1'b1);
    #2 PRESET = 1'b1;
    #1;
    check("t5_psel", PSEL, 1'b0);
    check("t5_penable", PENABLE, 1'b0);
    check("t5_busy", busy, 1'b0);
    tick();
    check("t5_no_rsp", rsp_valid, 4'b0000);
    PRESET = 1'b0;
    req_valid = 4'b1001; PREADY = 1'b1;
    wait_grant(g);
    check("t5_first", g, 0);
    req_valid = '0;
    repeat (4) tick();

    // Slave that never answers
    set_req(1, 1'b0, 32'h40, 32'h0);
    req_valid = 4'b0010; PREADY = 1'b0;
    tick();
    req_valid = '0;
    tick();
`ifdef APB_TIMEOUT_EN
    n = 0;
    while (rsp_valid == 0 && n < 40) begin
      if (PENABLE) n++;
      tick();
    end
    check("t6_cycles", n, TO);
    check("t6_rsp", rsp_valid, 4'b0010);
    check("t6_err", rsp_err, 1'b1);
    check("t6_rdata", rsp_rdata, 32'h0);
    tick();
    check("t6_idle", {PSEL, busy}, 2'b00);
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      check("t6_hold", {PSEL, PENABLE, busy}, 3'b111);
      tick();
    end
    PREADY = 1'b1;
    tick();
    check("t6_rsp", rsp_valid, 4'b0010);
    tick();
`endif

    // Randomized traffic
    repeat (400) begin
      req_valid = N'($urandom);
      req_write = N'($urandom);
      for (int i = 0; i < N; i++) set_req(i, req_write[i], $urandom, $urandom);
      PRDATA = $urandom;
      PREADY = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    PREADY = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
